// File: rtl/gap_pool_pkg.sv
// gap_pool_pkg: shared types, frame-size encodings and reciprocal constants for gap_pool_mc
package gap_pool_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, MUL, OUT} state_t;
    typedef enum logic [1:0] {MAP_28 = 2'd0, MAP_14 = 2'd1, MAP_7 = 2'd2, MAP_BAD = 2'd3} map_e;
    localparam int RECIP_SHIFT_D = 24;
    localparam int RECIP_W = 20;
    localparam int PIX_W = 10;
    localparam int N_PIX [3] = '{784, 196, 49};
    localparam int RECIP [3] = '{21400, 85598, 342392};
    function automatic logic [PIX_W-1:0] n_pix(input logic [1:0] m);
        return PIX_W'(m == MAP_7 ? N_PIX[2] : m == MAP_14 ? N_PIX[1] : N_PIX[0]);
    endfunction
    function automatic logic [RECIP_W-1:0] recip_of(input logic [1:0] m);
        return RECIP_W'(m == MAP_7 ? RECIP[2] : m == MAP_14 ? RECIP[1] : RECIP[0]);
    endfunction
endpackage

// File: rtl/gap_pool_mc_if.sv
// gap_pool_mc_if: control, input stream and output stream of the pooling block
interface gap_pool_mc_if #(parameter int DATA_W = 9, parameter int MAX_CH = 16);
    logic                        start;
    logic [1:0]                  map_size;
    logic [$clog2(MAX_CH+1)-1:0] num_ch;
    logic [DATA_W-1:0]           in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           out_data;
    logic [$clog2(MAX_CH)-1:0]   out_ch;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
    logic                        busy;
    logic                        cfg_err;
    modport master (output start, map_size, num_ch, in_data, in_valid, out_ready,
                    input in_ready, out_data, out_ch, out_valid, out_last, busy, cfg_err);
    modport slave (input start, map_size, num_ch, in_data, in_valid, out_ready,
                   output in_ready, out_data, out_ch, out_valid, out_last, busy, cfg_err);
endinterface

// File: rtl/gap_recip_div.sv
// gap_recip_div: registered sum x reciprocal product, then round-to-nearest and saturate
module gap_recip_div #(
    parameter int DATA_W = 9,
    parameter int SUM_W = 19,
    parameter int RECIP_W = 20,
    parameter int RECIP_SHIFT = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic [SUM_W-1:0]   i_acc,
    input  logic [RECIP_W-1:0] i_recip,
    output logic [DATA_W-1:0]  o_data
);
    localparam int PROD_W = SUM_W + RECIP_SHIFT - 4;
    localparam int R_W = PROD_W + 1;
    localparam int Q_W = PROD_W - RECIP_SHIFT + 1;
    logic [PROD_W-1:0] r_prod;
    logic [R_W-1:0]    w_round;
    logic [Q_W-1:0]    w_q;
    // capture the product only in MUL so the output stays put while stalled
    always_ff @(posedge clk) begin
        if (reset) r_prod <= '0;
        else if (i_en) r_prod <= PROD_W'(i_acc) * PROD_W'(i_recip);
    end
    assign w_round = R_W'(r_prod) + (R_W'(1) << (RECIP_SHIFT - 1));
    assign w_q = Q_W'(w_round >> RECIP_SHIFT);
    assign o_data = w_q > Q_W'((1 << DATA_W) - 1) ? '1 : w_q[DATA_W-1:0];
endmodule

// File: rtl/gap_pool_mc.sv
// gap_pool_mc: multi-channel global average pooling over 28x28/14x14/7x7 interleaved frames
module gap_pool_mc
    import gap_pool_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int MAX_CH = 16,
    parameter int SUM_W = DATA_W + 10,
    parameter int RECIP_SHIFT = RECIP_SHIFT_D
) (
    input logic clk,
    input logic reset,
    gap_pool_mc_if.slave bus
);
    localparam int CH_W = $clog2(MAX_CH + 1);
    localparam int IDX_W = $clog2(MAX_CH);
    state_t             r_state, w_next;
    logic [1:0]         r_map;
    logic [CH_W-1:0]    r_num;
    logic [IDX_W-1:0]   r_ch;
    logic [PIX_W-1:0]   r_pix;
    logic               r_cfg_err;
    logic [SUM_W-1:0]   r_acc [MAX_CH];
    logic               w_start_ok, w_beat, w_ch_last, w_pix_last;
    logic [SUM_W-1:0]   w_in_ext;
    assign w_start_ok = bus.start && bus.map_size != MAP_BAD && bus.num_ch != '0
                        && bus.num_ch <= CH_W'(MAX_CH);
    assign w_beat = bus.in_valid && r_state == ACCUM;
    assign w_ch_last = CH_W'(r_ch) == r_num - CH_W'(1);
    assign w_pix_last = r_pix == n_pix(r_map) - PIX_W'(1);
    assign w_in_ext = SUM_W'(bus.in_data);
    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    // next-state: frame ends on the last channel of the last pixel, output ends on the last channel
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start_ok ? ACCUM : IDLE;
            ACCUM:   w_next = (w_beat && w_ch_last && w_pix_last) ? MUL : ACCUM;
            MUL:     w_next = OUT;
            OUT:     w_next = bus.out_ready ? (w_ch_last ? IDLE : MUL) : OUT;
            default: w_next = IDLE;
        endcase
    end
    // config latch plus pixel/channel counters; ch wraps to 0 at frame end, ready for output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_map <= '0;
            r_num <= '0;
            r_ch  <= '0;
            r_pix <= '0;
        end else if (r_state == IDLE && w_start_ok) begin
            r_map <= bus.map_size;
            r_num <= bus.num_ch;
            r_ch  <= '0;
            r_pix <= '0;
        end else if (w_beat) begin
            r_ch  <= w_ch_last ? '0 : r_ch + IDX_W'(1);
            r_pix <= w_ch_last ? r_pix + PIX_W'(1) : r_pix;
        end else if (r_state == OUT && bus.out_ready && !w_ch_last) begin
            r_ch  <= r_ch + IDX_W'(1);
        end
    end
    // rejected start in IDLE raises a single-cycle error pulse
    always_ff @(posedge clk) begin
        if (reset) r_cfg_err <= 1'b0;
        else r_cfg_err <= r_state == IDLE && bus.start && !w_start_ok;
    end
    // first pixel overwrites, so stale sums from an aborted frame never leak in
    always_ff @(posedge clk) begin
        if (w_beat) r_acc[r_ch] <= r_pix == '0 ? w_in_ext : r_acc[r_ch] + w_in_ext;
    end
    gap_recip_div #(
        .DATA_W(DATA_W), .SUM_W(SUM_W), .RECIP_W(RECIP_W), .RECIP_SHIFT(RECIP_SHIFT)
    ) u_div (
        .clk(clk), .reset(reset), .i_en(r_state == MUL), .i_acc(r_acc[r_ch]),
        .i_recip(recip_of(r_map)), .o_data(bus.out_data)
    );
    assign bus.in_ready = r_state == ACCUM;
    assign bus.out_valid = r_state == OUT;
    assign bus.out_last = r_state == OUT && w_ch_last;
    assign bus.out_ch = r_ch;
    assign bus.busy = r_state != IDLE;
    assign bus.cfg_err = r_cfg_err;
endmodule
